// File: rtl/vga_pkg.sv
// Display timing shared by the VGA driver and its pixel sources, plus the
// small helpers the line fetcher needs.
package vga_pkg;

  localparam logic [9:0] SCREEN_X = 10'd640;
  localparam logic [9:0] H_FRONT  = 10'd16;
  localparam logic [9:0] H_SYNC   = 10'd96;
  localparam logic [9:0] H_BACK   = 10'd48;
  localparam logic [9:0] TOTAL_X  = SCREEN_X + H_FRONT + H_SYNC + H_BACK;

  localparam logic [9:0] SCREEN_Y = 10'd480;
  localparam logic [9:0] V_FRONT  = 10'd10;
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_BACK   = 10'd33;
  localparam logic [9:0] TOTAL_Y  = SCREEN_Y + V_FRONT + V_SYNC + V_BACK;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_DRAIN
  } fetch_state_e;

  // Start address of a 160-pixel source row: row*160 as row*128 + row*32.
  function automatic logic [14:0] row_base(input logic [6:0] row);
    logic [14:0] r;
    r = {8'd0, row};
    return (r << 7) + (r << 5);
  endfunction

endpackage

// File: rtl/line_buf_2bank.sv
// Ping-pong line buffer: the active bank feeds the display through an
// asynchronous read while the other bank is written from the frame buffer.
module line_buf_2bank #(
  parameter int DEPTH = 160,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             active_bank,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  // NOTE: storage has no reset; each entry is rewritten before its bank is
  // shown, and the pixel output is forced to 0 outside the visible area.
  logic [7:0] bank0 [DEPTH];
  logic [7:0] bank1 [DEPTH];

  // NOTE: clocked blocks use <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (active_bank) bank0[wr_idx] <= wr_data;
      else             bank1[wr_idx] <= wr_data;
    end
  end

  assign rd_data = active_bank ? bank1[rd_idx] : bank0[rd_idx];

endmodule

// File: rtl/vga_line_fetch.sv
// Fetches one 160-pixel source row per four display lines into a ping-pong
// buffer and presents it 4x upscaled to the 640x480 VGA driver.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int ADDR_W = 15,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        posX,
  input  logic [9:0]        posY,          // spans 0..TOTAL_Y-1 (524)
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [7:0]        pixel,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam int COL_W = $clog2(SRC_W);

  fetch_state_e      state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        drain_q, drain_d;
  logic              done_q, done_d;
  logic              line_fill_q, line_fill_d;
  logic              active_q, active_d;
  logic              underrun_q, underrun_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [COL_W-1:0]  wcol_q [RD_LAT];
  logic [COL_W-1:0]  wcol_d [RD_LAT];

  logic [9:0]       ny;
  logic [6:0]       row;
  logic             trigger, start, swap, visible;
  logic [COL_W-1:0] rd_idx;
  logic [7:0]       buf_data;

  // Fill the next source row on posX==0 of the last display line of the
  // current row, or of the last blanking line for row 0.
  always_comb begin
    ny      = (posY == TOTAL_Y - 10'd1) ? 10'd0 : posY + 10'd1;
    row     = ny[8:2];
    trigger = (posX == 10'd0) && (ny < SCREEN_Y) &&
              ((posY >= SCREEN_Y) || (row != posY[8:2])) &&
              (int'(row) < SRC_H);
    start   = trigger && (state_q == FETCH_IDLE);
    swap    = (posX == TOTAL_X - 10'd1) && line_fill_q;
    visible = (posX < SCREEN_X) && (posY < SCREEN_Y);
  end

  // NOTE: every _d is given its hold value first, so no branch infers a latch.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    addr_d      = addr_q;
    drain_d     = drain_q;
    done_d      = done_q;
    line_fill_d = swap ? 1'b0 : line_fill_q;
    case (state_q)
      FETCH_IDLE: begin
        if (start) begin
          state_d     = FETCH_REQ;
          col_d       = '0;
          addr_d      = ADDR_W'(row_base(row));
          done_d      = 1'b0;
          line_fill_d = 1'b1;
        end
      end
      FETCH_REQ: begin
        col_d  = col_q + COL_W'(1);
        addr_d = addr_q + ADDR_W'(1);
        if (col_q == COL_W'(SRC_W - 1)) begin
          state_d = FETCH_DRAIN;
          addr_d  = addr_q;
          drain_d = 2'd0;
        end
      end
      FETCH_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'(RD_LAT - 1)) begin
          state_d = FETCH_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  // Bank swap and sticky underrun; a set in the same cycle as a clear wins.
  always_comb begin
    active_d   = swap ? ~active_q : active_q;
    underrun_d = underrun_q;
    if (underrun_clr)    underrun_d = 1'b0;
    if (swap && !done_q) underrun_d = 1'b1;
  end

  // Column tags travel alongside each read until its data returns.
  always_comb begin
    vld_d     = vld_q;
    wcol_d    = wcol_q;
    vld_d[0]  = mem_rd;
    wcol_d[0] = col_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      wcol_d[i] = wcol_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH_IDLE;
      col_q       <= '0;
      addr_q      <= '0;
      drain_q     <= 2'd0;
      done_q      <= 1'b0;
      line_fill_q <= 1'b0;
      active_q    <= 1'b0;
      underrun_q  <= 1'b0;
      vld_q       <= '0;
      for (int i = 0; i < RD_LAT; i++) wcol_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      drain_q     <= drain_d;
      done_q      <= done_d;
      line_fill_q <= line_fill_d;
      active_q    <= active_d;
      underrun_q  <= underrun_d;
      vld_q       <= vld_d;
      for (int i = 0; i < RD_LAT; i++) wcol_q[i] <= wcol_d[i];
    end
  end

  assign mem_rd   = (state_q == FETCH_REQ);
  assign mem_addr = addr_q;
  assign underrun = underrun_q;
  assign rd_idx   = visible ? COL_W'(posX[9:2]) : '0;
  assign pixel    = visible ? buf_data : 8'd0;

  line_buf_2bank #(
    .DEPTH(SRC_W),
    .IDX_W(COL_W)
  ) u_line_buf (
    .clk        (clk),
    .active_bank(active_q),
    .wr_en      (vld_q[RD_LAT-1]),
    .wr_idx     (wcol_q[RD_LAT-1]),
    .wr_data    (mem_data),
    .rd_idx     (rd_idx),
    .rd_data    (buf_data)
  );

endmodule
